// File: rtl/encoder_nbit_seq.sv
// encoder_nbit_seq: captures a 2**N-bit request vector and emits each set-bit index, lowest first, one per valid&ready handshake; ports clk, reset, load, d, ready -> a, valid, busy, done, count
module encoder_nbit_seq #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [(1<<N)-1:0]   d,
  input  logic                ready,
  output logic [N-1:0]        a,
  output logic                valid,
  output logic                busy,
  output logic                done,
  output logic [N:0]          count
);
  localparam int W = 1 << N;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, nxt;
  logic [W-1:0] pend, rem;
  logic accept, cap;
  function automatic logic [N-1:0] lowest(input logic [W-1:0] v);
    lowest = '0;
    for (int i = W - 1; i >= 0; i--) if (v[i]) lowest = i[N-1:0];
  endfunction
  function automatic logic [N:0] popcount(input logic [W-1:0] v);
    popcount = '0;
    for (int i = 0; i < W; i++) popcount = popcount + {{N{1'b0}}, v[i]};
  endfunction
  assign accept = state == SCAN && ready;
  assign cap = state == IDLE && load;
  assign rem = pend & ~(W'(1) << a);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (cap && d != '0) nxt = SCAN;
    if (accept && rem == '0) nxt = IDLE;
  end
  always_comb begin
    valid = state == SCAN;
    busy = state == SCAN;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pend <= '0;
      a <= '0;
      count <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cap) begin
        pend <= d;
        a <= lowest(d);
        count <= popcount(d);
        done <= d == '0;
      end else if (accept) begin
        pend <= rem;
        a <= lowest(rem);
        count <= rem == '0 ? '0 : count - (N+1)'(1);
        done <= rem == '0;
      end
    end
endmodule

// File: tb/tb_encoder_nbit_seq.sv
// tb_encoder_nbit_seq: directed and randomized checks of encoder_nbit_seq against a queue-based model
module tb_encoder_nbit_seq;
  localparam int N = 3;
  localparam int W = 1 << N;
  logic clk = 0, reset = 1, load = 0, ready = 0;
  logic [W-1:0] d = '0;
  logic [N-1:0] a;
  logic valid, busy, done;
  logic [N:0] count;
  int total = 0, bad = 0;
  int q[$];
  bit md = 0, armed = 0;
  encoder_nbit_seq #(.N(N)) dut (
    .clk(clk), .reset(reset), .load(load), .d(d), .ready(ready),
    .a(a), .valid(valid), .busy(busy), .done(done), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      md = 0;
      armed = 1;
    end else begin
      md = 0;
      if (q.size() == 0) begin
        if (load) begin
          if (d == '0) md = 1;
          else for (int k = 0; k < W; k++) if (d[k]) q.push_back(k);
        end
      end else if (ready) begin
        void'(q.pop_front());
        if (q.size() == 0) md = 1;
      end
    end
  end
  always @(negedge clk)
    if (armed) begin
      chk("m_valid", int'(valid), int'(q.size() != 0));
      chk("m_busy", int'(busy), int'(q.size() != 0));
      chk("m_count", int'(count), q.size());
      chk("m_done", int'(done), int'(md));
      if (q.size() != 0) chk("m_a", int'(a), q[0]);
    end
  initial begin
    step();
    step();
    reset = 0;
    step();
    chk("rst_a", int'(a), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    load = 1; d = 8'b1010_0101; ready = 1;
    step();
    load = 0;
    chk("t2_a0", int'(a), 0); chk("t2_c0", int'(count), 4); chk("t2_v0", int'(valid), 1);
    step();
    chk("t2_a1", int'(a), 2); chk("t2_c1", int'(count), 3);
    step();
    chk("t2_a2", int'(a), 5); chk("t2_c2", int'(count), 2);
    step();
    chk("t2_a3", int'(a), 7); chk("t2_c3", int'(count), 1);
    step();
    chk("t2_valid_end", int'(valid), 0); chk("t2_done", int'(done), 1);
    step();
    chk("t2_done_off", int'(done), 0); chk("t2_busy_off", int'(busy), 0);
    load = 1; d = 8'b1000_0001;
    step();
    load = 0;
    chk("t3_a0", int'(a), 0);
    step();
    ready = 0;
    chk("t3_a7", int'(a), 7);
    step();
    chk("t3_stall1_a", int'(a), 7); chk("t3_stall1_v", int'(valid), 1);
    step();
    ready = 1;
    chk("t3_stall2_a", int'(a), 7); chk("t3_stall2_c", int'(count), 1);
    step();
    chk("t3_done", int'(done), 1); chk("t3_valid", int'(valid), 0);
    load = 1; d = '0;
    step();
    load = 0;
    chk("t4_done", int'(done), 1); chk("t4_valid", int'(valid), 0); chk("t4_busy", int'(busy), 0);
    step();
    chk("t4_done_off", int'(done), 0);
    load = 1; d = 8'hFF;
    step();
    load = 0;
    chk("t5_c0", int'(count), 8); chk("t5_a0", int'(a), 0);
    step();
    step();
    chk("t5_a2", int'(a), 2);
    load = 1; d = 8'h01;
    step();
    load = 0;
    chk("t5_a3_ignore", int'(a), 3); chk("t5_c3", int'(count), 5);
    for (int k = 4; k < 8; k++) begin
      step();
      chk("t5_seq", int'(a), k);
    end
    step();
    chk("t5_done", int'(done), 1);
    load = 1; d = 8'h10;
    step();
    load = 0;
    chk("t5_b2b_a", int'(a), 4); chk("t5_b2b_v", int'(valid), 1);
    step();
    step();
    load = 1; d = 8'hF0;
    step();
    load = 0;
    chk("t6_a4", int'(a), 4);
    step();
    chk("t6_a5", int'(a), 5);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("t6_valid", int'(valid), 0); chk("t6_count", int'(count), 0);
    chk("t6_busy", int'(busy), 0); chk("t6_done", int'(done), 0);
    step();
    chk("t6_nodone", int'(done), 0);
    load = 1; d = 8'h02;
    step();
    load = 0;
    chk("t6_a1", int'(a), 1);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 99) == 0;
      load = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 3))
        0: d = '0;
        1: d = W'(1) << $urandom_range(0, W - 1);
        2: d = W'($urandom) & W'($urandom);
        default: d = W'($urandom);
      endcase
      ready = $urandom_range(0, 3) != 0;
      step();
    end
    reset = 0; load = 0; ready = 1;
    repeat (12) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/encoder_nbit_seq.md
Name: encoder_nbit_seq

Overview:
- Sequential encoder: the inverse direction of the team's parameterized n-bit decoder.
- Captures a 2**N-bit request vector and emits the binary index of every set bit, lowest index first, one index per accepted handshake.
- Sits upstream of decoder_nbit-style consumers. Each emitted index fed into a decoder with enable=1 reproduces one set bit of the captured vector.

Parameters:
N, 3, index width; request vector width is 2**N

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  capture request: d is sampled when load=1 and the block is idle
d  input  2**N  request vector; bit k set means index k is to be emitted
ready  input  1  consumer accepts the index on a cycle where valid=1 and ready=1
a  output  N  encoded index, registered; meaningful only while valid=1
valid  output  1  a holds a pending index, registered
busy  output  1  1 while a capture is being serialized (state SCAN)
done  output  1  one-cycle pulse when the last index of a capture is accepted, or when an empty vector is loaded
count  output  N+1  number of indices still pending, including the one on a

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk.
  - reset is synchronous and active-high.
  - While reset=1 at an edge: state=IDLE, pend=0, a=0, valid=0, busy=0, done=0, count=0. No output is undefined after the first reset edge.
- Reset mid-operation: the pending vector is discarded. No done pulse is produced. The capture is abandoned.
- State IDLE (busy=0, valid=0):
  - load=1, d!=0: pend<=d, a<=index of lowest set bit of d, valid<=1, count<=popcount(d), go to SCAN.
  - load=1, d==0: done<=1 for exactly one cycle, stay IDLE, valid stays 0.
  - load=0: hold.
- State SCAN (busy=1, valid=1):
  - valid&ready=1: clear bit a in pend; count<=count-1.
    - If the remaining pend!=0: a<=lowest set bit of the remaining pend, valid stays 1.
    - If the remaining pend==0: valid<=0, count<=0, done<=1 for one cycle, go to IDLE.
  - ready=0: a, valid, count and pend hold. Index stability is required while stalled.
  - load is ignored in SCAN. d is not sampled, and no error is flagged.
- Latency and throughput:
  - load at edge t gives valid=1 after edge t.
  - With ready held at 1, one index is emitted per cycle. A vector with P set bits finishes in P cycles after capture.
  - done pulses in the cycle after the final accept.
- Back-to-back captures: load asserted in the same cycle that done=1 (state IDLE) is accepted. No dead cycle is required beyond the done cycle.
- done is registered and deasserts automatically the next cycle.
- Arithmetic and priority:
  - Lowest-index-first priority.
  - count is N+1 bits so that all-ones (2**N) is representable.
  - Index is exact for k=0..2**N-1. a wraps nowhere; the MSB index 2**N-1 is valid.
- All outputs are registered. There is no combinational path from ready or load to any output.
- Implementation intent: a two-state FSM, a 2**N-bit pending register, a parameterized lowest-set-bit priority encoder (for loop over 2**N bits), and a popcount for count initialization. Fully parameterized in N; must synthesize for N=1..6.

Test Plan:
1. reset=1 for 2 cycles, then reset=0 with load=0 -> a=0, valid=0, busy=0, done=0, count=0.
2. N=3, load=1 with d=8'b1010_0101, ready=1 held high.
   - Required: valid=1 on the next 4 cycles with a=0,2,5,7 and count=4,3,2,1.
   - Required: then valid=0 with done=1 for exactly 1 cycle, followed by busy=0.
3. d=8'b1000_0001, ready toggling 1,0,0,1.
   - Required: a=0 is accepted, then a=7 holds stable with valid=1 through both stall cycles and is accepted on the 4th cycle.
   - Required: done then pulses.
4. load=1 with d=0 in IDLE -> done=1 for one cycle, valid never asserts, busy stays 0.
5. Load d=8'hFF with ready=1. Assert load with d=8'h01 at the 3rd emission.
   - Required: the mid-SCAN load is ignored; all indices 0..7 are emitted with initial count=8.
   - Required: a load of d=8'h10 issued in the done cycle produces a=4, valid=1 on the next cycle.
6. Load d=8'hF0, accept two indices (a=4,5), then assert reset=1 for 1 cycle.
   - Required: valid=0, count=0 and busy=0 after the reset edge, with no done pulse.
   - Required: a subsequent load of d=8'h02 emits a=1.
